spi_frame_sequencer: RTL and testbench

//   Sequences one SPI transmit frame: walks a byte buffer from a base address and fetches each byte.

---
 rtl/spi_frame_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer
//   Sends one SPI transmit frame. It reads bytes from a frame buffer, starting
//   at a base address, and offers each byte to the SPI byte shifter over a
//   valid/ready handshake. cs_n is held low from the accepted start until the
//   shifter has drained. cs_n then stays high for a guard gap, after which
//   done pulses.
//
//   Optional feature macro: SPI_SEQ_ABORT_EN adds the abort/aborted ports.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               frame request (only looked at in IDLE)
//   base_addr/frame_len frame descriptor, latched when start is accepted
//   mem_rd/mem_addr     1-cycle buffer read; mem_rdata returns the next cycle
//   tx_valid/tx_data    byte offered to the shifter; tx_ready accepts it
//   tx_idle             the shifter has shifted out its last bit
//   cs_n                SPI chip select, active-low
//   busy/done/addr      status: not idle / end-of-frame pulse / debug address
//   abort/aborted       (SPI_SEQ_ABORT_EN only) cut the frame short / marks that frame's done
module spi_frame_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] frame_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              tx_idle,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
`ifdef SPI_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [ADDR_W-1:0] addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [7:0]        GAP_END = 8'(GAP_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, idx_q, idx_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        gap_q, gap_d;
`ifdef SPI_SEQ_ABORT_EN
  logic              ab_flag_q, ab_flag_d;
  logic              aborted_q, aborted_d;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    cs_n_d     = cs_n_q;
    done_d     = 1'b0;
    gap_d      = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            // Issue the first read together with the state change. That way
            // mem_rd is a registered output and stays high for all of FETCH.
            base_d     = base_addr;
            len_d      = frame_len;
            idx_d      = '0;
            cs_n_d     = 1'b0;
            mem_rd_d   = 1'b1;
            mem_addr_d = base_addr;
            state_d    = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        tx_data_d  = mem_rdata;
        tx_valid_d = 1'b1;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          idx_d      = idx_q + ONE;
          // The compare is against len-1, so a full-range length never
          // needs idx to reach 2**ADDR_W.
          if (idx_q == len_q - ONE) begin
            state_d = S_DRAIN;
          end else begin
            mem_rd_d   = 1'b1;
            mem_addr_d = base_q + idx_q + ONE;  // wraps modulo 2**ADDR_W
            state_d    = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (tx_idle) begin
          cs_n_d = 1'b1;
          // The done cycle is the last of the GAP_CYC cs_n-high cycles.
          if (GAP_CYC == 1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            gap_d   = 8'd1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_END) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SPI_SEQ_ABORT_EN
    ab_flag_d = ab_flag_q;
    aborted_d = 1'b0;
    // Abort drops any pending offer or read. A byte that was already
    // handshaken still shifts out, because DRAIN waits for tx_idle.
    if (abort && (state_q == S_FETCH || state_q == S_WAIT || state_q == S_ISSUE)) begin
      state_d    = S_DRAIN;
      tx_valid_d = 1'b0;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      ab_flag_d  = 1'b1;
    end
    if (done_d) begin
      aborted_d = ab_flag_q;
      ab_flag_d = 1'b0;
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gap_q      <= '0;
`ifdef SPI_SEQ_ABORT_EN
      ab_flag_q  <= 1'b0;
      aborted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gap_q      <= gap_d;
`ifdef SPI_SEQ_ABORT_EN
      ab_flag_q  <= ab_flag_d;
      aborted_q  <= aborted_d;
`endif
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign addr     = mem_addr_q;  // debug mirror of the read address
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign cs_n     = cs_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef SPI_SEQ_ABORT_EN
  assign aborted  = aborted_q;
`endif

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Testbench for spi_frame_sequencer. A negedge monitor logs bus events with
// cycle stamps. After each frame, the logs are compared with the outcome
// expected from the frame descriptor, the buffer contents and the observed
// tx_ready/tx_idle pattern.
module tb_spi_frame_sequencer;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0;
  logic [7:0] base_addr = '0, frame_len = '0;
  logic       mem_rd;
  logic [7:0] mem_addr, mem_rdata = '0, tx_data, addr;
  logic       tx_valid, tx_ready = 1'b0, tx_idle = 1'b1;
  logic       cs_n, busy, done;
`ifdef SPI_SEQ_ABORT_EN
  logic       abort = 1'b0, aborted;
`endif

  spi_frame_sequencer #(.ADDR_W(8), .DATA_W(8), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .frame_len(frame_len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_idle(tx_idle),
    .cs_n(cs_n), .busy(busy), .done(done),
`ifdef SPI_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .addr(addr));

  always #5 clk = ~clk;

  // Frame buffer: read data appears the cycle after the strobe.
  logic [7:0] mem [0:255];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int checks = 0, failures = 0;
  int cyc = 0;
  int rdy_pct = 100, idle_pct = 100;

  // Event logs
  logic [7:0] rd_addr[$], hs_data[$];
  int rd_cyc[$], hs_cyc[$], vrise[$], done_cyc[$], ab_cyc[$];
  int cs_low, busy_cnt, stab_err, mirr_err;
  bit idle_log [0:65535];
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;

  always @(negedge clk) begin
    if (mem_rd) begin rd_addr.push_back(mem_addr); rd_cyc.push_back(cyc); end
    if (tx_valid && tx_ready) begin hs_data.push_back(tx_data); hs_cyc.push_back(cyc); end
    if (tx_valid && !pv) vrise.push_back(cyc);
    if (pv && !pr && !(tx_valid && tx_data == pd)) stab_err++;
    if (done) done_cyc.push_back(cyc);
    if (!cs_n) cs_low++;
    if (busy) busy_cnt++;
    if (addr !== mem_addr) mirr_err++;
`ifdef SPI_SEQ_ABORT_EN
    if (aborted) ab_cyc.push_back(cyc);
`endif
    idle_log[cyc] = tx_idle;
    pv = tx_valid; pr = tx_ready; pd = tx_data;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_addr.delete(); hs_data.delete(); rd_cyc.delete(); hs_cyc.delete();
    vrise.delete(); done_cyc.delete(); ab_cyc.delete();
    cs_low = 0; busy_cnt = 0; stab_err = 0; mirr_err = 0;
  endtask

  // Advance to just after the next rising edge. start is a single-cycle
  // pulse, and the descriptor inputs are scrambled to prove they are latched.
  task automatic tick();
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 8'($urandom);
    frame_len = 8'($urandom);
    tx_ready  = (int'($urandom_range(99)) < rdy_pct);
    tx_idle   = (int'($urandom_range(99)) < idle_pct);
  endtask

  task automatic start_frame(input logic [7:0] b, input logic [7:0] l, output int t0);
    tick();
    start = 1'b1; base_addr = b; frame_len = l;
    t0 = cyc;
  endtask

  task automatic wait_valid();
    tick();
    for (int k = 0; k < 50 && tx_valid !== 1'b1; k++) tick();
    chk("valid_seen", {31'd0, tx_valid}, 32'd1);
  endtask

  // Run until done. The optional poke pulses start mid-frame, which must be
  // ignored. The optional chain restarts on the done cycle with (nb, nl).
  task automatic wait_done(input int t0, input int bud, input bit poke, input bit chain,
                           input logic [7:0] nb, input logic [7:0] nl, output int dn);
    for (int k = 0; k < bud; k++) begin
      tick();
      if (poke && cyc == t0 + 2) start = 1'b1;
      if (done === 1'b1) break;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    dn = cyc;
    if (chain) begin start = 1'b1; base_addr = nb; frame_len = nl; end
    @(negedge clk); #1;
  endtask

  task automatic check_frame(input int t0, input logic [7:0] b, input logic [7:0] l);
    int cd, last;
    if (l == 0) begin
      chk("empty_rd", rd_addr.size(), 0);
      chk("empty_done_cnt", done_cyc.size(), 1);
      if (done_cyc.size() > 0) chk("empty_done_cyc", done_cyc[0], t0 + 1);
      chk("empty_cs_low", cs_low, 0);
      chk("empty_busy", busy_cnt, 0);
    end else begin
      chk("rd_count", rd_addr.size(), l);
      for (int i = 0; i < rd_addr.size() && i < int'(l); i++)
        chk("rd_addr", rd_addr[i], (int'(b) + i) & 32'hFF);
      if (rd_cyc.size() > 0) chk("first_rd_cyc", rd_cyc[0], t0 + 1);
      chk("hs_count", hs_data.size(), l);
      for (int i = 0; i < hs_data.size() && i < int'(l); i++)
        chk("tx_data", hs_data[i], mem[8'(int'(b) + i)]);
      chk("vrise_count", vrise.size(), l);
      if (vrise.size() > 0) chk("first_valid_lat", vrise[0], t0 + 3);
      for (int i = 1; i < vrise.size() && i < hs_cyc.size() + 1; i++)
        chk("next_valid_lat", vrise[i], hs_cyc[i-1] + 3);
      // The shifter drains on the first tx_idle cycle at or after the last handshake's next cycle.
      cd = -1000;
      if (hs_cyc.size() > 0) begin
        last = hs_cyc[hs_cyc.size()-1];
        cd = last + 1;
        while (!idle_log[cd] && cd < last + 400) cd++;
      end
      chk("done_cnt", done_cyc.size(), 1);
      if (done_cyc.size() > 0) chk("done_cyc", done_cyc[0], cd + GAP);
      chk("cs_low_cycles", cs_low, cd - t0);
      chk("busy_cycles", busy_cnt, cd + GAP - t0 - 1);
      chk("tx_hold", stab_err, 0);
    end
    chk("addr_mirror", mirr_err, 0);
`ifdef SPI_SEQ_ABORT_EN
    chk("aborted_quiet", ab_cyc.size(), 0);
`endif
  endtask

  initial begin
    int t0, dn, bad;
    logic [7:0] b, l, nb, nl;
    bit chain, started;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'hFF;

    // Reset held for two edges.
    tick(); tick();
    rst = 1'b0;
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_addr", {24'd0, addr}, 32'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cs_n !== 1'b1 || busy !== 1'b0 || mem_rd !== 1'b0 || tx_valid !== 1'b0) bad++;
    end
    chk("idle_20", bad, 0);
    clear_logs();

    // Basic frame, ready tied high
    rdy_pct = 100; idle_pct = 100;
    start_frame(8'h10, 8'd3, t0);
    wait_done(t0, 100, 0, 0, 0, 0, dn);
    check_frame(t0, 8'h10, 8'd3);
    clear_logs();

    // Backpressure on byte 2 for 5 cycles
    rdy_pct = 0;
    start_frame(8'h10, 8'd3, t0);
    wait_valid(); tx_ready = 1'b1;
    wait_valid();
    for (int k = 0; k < 4; k++) tick();
    rdy_pct = 100;
    wait_done(t0, 100, 0, 0, 0, 0, dn);
    check_frame(t0, 8'h10, 8'd3);
    clear_logs();

    // Address wrap, then an empty frame
    start_frame(8'hFE, 8'd4, t0);
    wait_done(t0, 100, 0, 0, 0, 0, dn);
    check_frame(t0, 8'hFE, 8'd4);
    clear_logs();
    start_frame(8'h33, 8'd0, t0);
    wait_done(t0, 20, 0, 0, 0, 0, dn);
    check_frame(t0, 8'h33, 8'd0);
    clear_logs();

    // Mid-frame start ignored; start on done cycle starts next frame
    start_frame(8'h20, 8'd2, t0);
    wait_done(t0, 100, 1, 1, 8'h50, 8'd2, dn);
    check_frame(t0, 8'h20, 8'd2);
    clear_logs();
    t0 = dn;
    wait_done(t0, 100, 0, 0, 0, 0, dn);
    check_frame(t0, 8'h50, 8'd2);
    clear_logs();

    // Full-range length
    start_frame(8'h05, 8'd255, t0);
    wait_done(t0, 3000, 0, 0, 0, 0, dn);
    check_frame(t0, 8'h05, 8'd255);
    clear_logs();

    // Randomized frames with random handshake/drain timing and chaining
    started = 0;
    nb = 8'($urandom); nl = 8'($urandom_range(0, 6));
    for (int f = 0; f < 12; f++) begin
      b = nb; l = nl;
      rdy_pct = int'($urandom_range(30, 100)); idle_pct = int'($urandom_range(30, 100));
      if (!started) start_frame(b, l, t0);
      chain = (f < 11) && ($urandom_range(1) == 1);
      nb = 8'($urandom); nl = 8'($urandom_range(0, 6));
      wait_done(t0, 500, $urandom_range(1) == 1, chain, nb, nl, dn);
      check_frame(t0, b, l);
      clear_logs();
      started = chain;
      t0 = dn;
    end

    // Reset while a byte is being offered
    rdy_pct = 0; idle_pct = 100;
    start_frame(8'h40, 8'd2, t0);
    wait_valid();
    rst = 1'b1;
    tick();
    chk("rst_mid_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(); tick();
    clear_logs();

`ifdef SPI_SEQ_ABORT_EN
    // Abort while byte 2 of 3 is offered
    start_frame(8'h80, 8'd3, t0);
    wait_valid(); tx_ready = 1'b1;
    wait_valid();
    abort = 1'b1; bad = cyc;
    tick(); abort = 1'b0;
    wait_done(t0, 100, 0, 0, 0, 0, dn);
    chk("abort_rd_count", rd_addr.size(), 2);
    chk("abort_hs_count", hs_data.size(), 1);
    chk("abort_done_cnt", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("abort_done_cyc", done_cyc[0], bad + 1 + GAP);
    chk("aborted_cnt", ab_cyc.size(), 1);
    if (ab_cyc.size() > 0 && done_cyc.size() > 0) chk("aborted_with_done", ab_cyc[0], done_cyc[0]);
    clear_logs();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
